// File: rtl/interface_control.sv
// interface_control: frames three UART bytes (operation, data_a, data_b) into one registered command.
// Optional inter-byte timeout with frame_error pulse when INTERFACE_CONTROL_TIMEOUT_EN is defined.
module interface_control #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_data_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] operation,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              cmd_valid,
    output logic              busy,
    output logic              frame_error
);
    typedef enum logic [1:0] {IDLE, GOT_OP, GOT_A} state_t;

    state_t            state;
    logic              prev_ready;
    logic [DATA_W-1:0] op_sh;
    logic [DATA_W-1:0] a_sh;
    logic              accept;

    // a strobe held high for several cycles delivers only one byte
    assign accept = rx_data_ready & ~prev_ready;

`ifdef INTERFACE_CONTROL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;
`else
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_ready <= 1'b0;
            op_sh      <= '0;
            a_sh       <= '0;
            operation  <= '0;
            data_a     <= '0;
            data_b     <= '0;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef INTERFACE_CONTROL_TIMEOUT_EN
            idle_cnt    <= '0;
            frame_error <= 1'b0;
`endif
        end else begin
            prev_ready <= rx_data_ready;
            cmd_valid  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_sh <= rx_data;
                    state <= GOT_OP;
                    busy  <= 1'b1;
                end
                GOT_OP: if (accept) begin
                    a_sh  <= rx_data;
                    state <= GOT_A;
                end
                GOT_A: if (accept) begin
                    operation <= op_sh;
                    data_a    <= a_sh;
                    data_b    <= rx_data;
                    cmd_valid <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
`ifdef INTERFACE_CONTROL_TIMEOUT_EN
            // an accept in the timeout cycle wins because it bypasses this branch
            frame_error <= 1'b0;
            if (state != IDLE && !accept) begin
                if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    op_sh       <= '0;
                    a_sh        <= '0;
                    idle_cnt    <= '0;
                    frame_error <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_interface_control.sv
// tb_interface_control: directed and randomized checks of interface_control against a byte-queue model.
module tb_interface_control;
    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 0;
    logic         reset = 1;
    logic         rx_data_ready = 0;
    logic [W-1:0] rx_data = '0;
    logic [W-1:0] operation, data_a, data_b;
    logic         cmd_valid, busy, frame_error;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q[$];
    logic         m_prev = 0;
    int           m_idle = 0;
    logic [W-1:0] e_op = 0, e_a = 0, e_b = 0;
    logic         e_valid = 0, e_busy = 0, e_err = 0;
    int           valid_count = 0;
    int           err_count = 0;

    interface_control #(.DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .operation(operation), .data_a(data_a), .data_b(data_b),
        .cmd_valid(cmd_valid), .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic acc;
        e_valid = 0;
        e_err   = 0;
        if (reset) begin
            q.delete();
            m_prev = 0;
            m_idle = 0;
            e_op = 0; e_a = 0; e_b = 0;
        end else begin
            acc = rx_data_ready && !m_prev;
            m_prev = rx_data_ready;
            if (acc) begin
                q.push_back(rx_data);
                m_idle = 0;
                if (q.size() == 3) begin
                    e_op = q[0]; e_a = q[1]; e_b = q[2];
                    e_valid = 1;
                    q.delete();
                end
            end else if (q.size() != 0) begin
`ifdef INTERFACE_CONTROL_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    q.delete();
                    m_idle = 0;
                    e_err = 1;
                end
`endif
            end
        end
        e_busy = q.size() != 0;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("cmd_valid", W'(cmd_valid), W'(e_valid));
        chk("busy", W'(busy), W'(e_busy));
        chk("frame_error", W'(frame_error), W'(e_err));
        chk("operation", operation, e_op);
        chk("data_a", data_a, e_a);
        chk("data_b", data_b, e_b);
        if (cmd_valid === 1'b1) valid_count++;
        if (frame_error === 1'b1) err_count++;
    endtask

    task automatic pulse(input logic [W-1:0] b, input int hold);
        rx_data_ready = 1;
        rx_data = b;
        repeat (hold) tick();
        rx_data_ready = 0;
        rx_data = W'($urandom);
        tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        do_reset();
        chk("reset_op", operation, 8'h00);
        chk("reset_busy", W'(busy), 8'h00);

        pulse(8'h08, 1); pulse(8'h09, 1); pulse(8'h0A, 1);
        chk("basic_op", operation, 8'h08);
        chk("basic_b", data_b, 8'h0A);

        valid_count = 0;
        pulse(8'h08, 5); pulse(8'h01, 1); pulse(8'h02, 1);
        chk("held_frames", W'(valid_count), 8'd1);
        chk("held_a", data_a, 8'h01);

        valid_count = 0;
        pulse(8'h03, 1); pulse(8'h04, 1);
        chk("partial_no_valid", W'(valid_count), 8'd0);
        do_reset();
        pulse(8'h05, 1); pulse(8'h06, 1); pulse(8'h07, 1);
        chk("after_reset_op", operation, 8'h05);
        chk("after_reset_b", data_b, 8'h07);

        valid_count = 0;
        pulse(8'h01, 1); pulse(8'h02, 1); pulse(8'h03, 1);
        pulse(8'hFF, 1); pulse(8'h00, 1); pulse(8'h80, 1);
        chk("b2b_count", W'(valid_count), 8'd2);
        chk("b2b_op", operation, 8'hFF);
        chk("b2b_a", data_a, 8'h00);

`ifdef INTERFACE_CONTROL_TIMEOUT_EN
        err_count = 0;
        pulse(8'h08, 1);
        repeat (20) tick();
        chk("timeout_err", W'(err_count), 8'd1);
        chk("timeout_busy", W'(busy), 8'h00);
        chk("timeout_op", operation, 8'hFF);
`endif

        for (int i = 0; i < 300; i++) begin
            rx_data_ready = 1;
            rx_data = W'($urandom);
            tick();
            repeat ($urandom_range(0, 3)) begin
                rx_data = W'($urandom);
                tick();
            end
            rx_data_ready = 0;
            repeat ($urandom_range(1, 3)) tick();
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
